div_seq: RTL and testbench

Multi-cycle sequential integer divider controller for the CPU's HI/LO divide path. Accepts a one-cycle `start` request and runs a restoring divide, one quotient bit per clock. Handles signed or unsigned operands and returns quotient on `lo` and remainder on `hi` with a one-cycle `done` pulse. Replaces the single-cycle combinational divide in the execute stage so the ALU critical path no longer carries a 32-deep subtract chain.

---
 rtl/div_pkg.sv | 29 ++
 rtl/div_step.sv | 43 ++++
 rtl/div_seq.sv | 142 ++++++++++++++
 tb/tb_div_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared constants and types for the sequential divider:
//                default operand width, step-counter width and the
//                2-bit controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Default operand/result width for the HI/LO divide path
    localparam int DIV_WIDTH = 32;

    // Step counter only has to reach DIV_WIDTH-1
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    // Controller state encoding (explicit 2-bit)
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_fix  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_st_idle,
        ST_CALC = c_st_calc,
        ST_FIX  = c_st_fix
    } div_state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division step. Shifts {A,Q}
//                left by one, trial-subtracts M from the new A and keeps the
//                difference only when it is non-negative.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_q
);

    // Partial remainder after the shift; needs one extra bit because 2A+1
    // can exceed WIDTH bits before the subtract.
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    assign w_shift = {i_a, i_q[WIDTH-1]};

    // A < M holds before every step, so the trial result always lies in
    // (-2^WIDTH, 2^WIDTH) and its top bit is a clean sign bit.
    assign w_diff = w_shift - {1'b0, i_m};

    // Restore or commit depending on the sign of the trial subtraction
    always_comb begin
        o_a = w_shift[WIDTH-1:0];
        o_q = {i_q[WIDTH-2:0], 1'b0};
        if (!w_diff[WIDTH]) begin
            o_a = w_diff[WIDTH-1:0];
            o_q = {i_q[WIDTH-2:0], 1'b1};
        end
    end

endmodule : div_step
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq
//  Description : Multi-cycle signed/unsigned restoring divider for the HI/LO
//                path. One quotient bit per clock; quotient on lo, remainder
//                on hi, one-cycle done pulse. Divide-by-zero runs full
//                latency and returns lo=all-ones, hi=dividend.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div_by_zero
);

    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_orig;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_dbz;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_q_nxt;

    // Operand magnitudes; the most-negative value maps onto 2^(WIDTH-1)
    // which is representable once treated as unsigned.
    assign w_dvd_neg = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg = is_signed & divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
    assign w_dvs_mag = w_dvs_neg ? (~divisor + 1'b1)  : divisor;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_a (r_a),
        .i_q (r_q),
        .i_m (r_m),
        .o_a (w_a_nxt),
        .o_q (w_q_nxt)
    );

    // Controller FSM: operand capture, iteration, sign fix-up and results
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_orig  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_zero  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= '0;
                        r_q     <= w_dvd_mag;
                        r_m     <= w_dvs_mag;
                        r_orig  <= dividend;
                        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r <= w_dvd_neg;
                        r_zero  <= (divisor == '0);
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_a   <= w_a_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // A zero divisor overrides whatever the datapath produced
                    if (r_zero) begin
                        r_lo  <= '1;
                        r_hi  <= r_orig;
                        r_dbz <= 1'b1;
                    end else begin
                        r_lo  <= r_neg_q ? (~r_q + 1'b1) : r_q;
                        r_hi  <= r_neg_r ? (~r_a + 1'b1) : r_a;
                        r_dbz <= 1'b0;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign lo          = r_lo;
    assign hi          = r_hi;
    assign div_by_zero = r_dbz;

endmodule : div_seq
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_seq
//  Description : Self-checking bench for div_seq. Expected results are queued
//                when a start is issued and compared when done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq;

    localparam int W   = 32;
    localparam int LAT = 33;

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
    } exp_t;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         div_by_zero;

    exp_t        scb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int unsigned cyc_cnt = 0;
    int unsigned start_cyc = 0;

    div_seq #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .lo          (lo),
        .hi          (hi),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Truncating division reference computed in 64 bits
    function automatic exp_t ref_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sd;
        longint qq;
        longint rr;
        if (b == '0) begin
            e.lo  = '1;
            e.hi  = a;
            e.dbz = 1'b1;
            return e;
        end
        if (sgn) begin
            sa = longint'($signed(a));
            sd = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sd = longint'({32'b0, b});
        end
        qq    = sa / sd;
        rr    = sa % sd;
        e.lo  = qq[W-1:0];
        e.hi  = rr[W-1:0];
        e.dbz = 1'b0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a start in the current cycle; optionally queue its expected result
    task automatic drive_start(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit push, input exp_t e);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        if (push) scb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) start_cyc = cyc_cnt;
    endtask

    task automatic issue(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input exp_t e);
        @(negedge clk);
        drive_start(sgn, a, b, push, e);
    endtask

    // Wait (bounded) for done, then pop and compare the scoreboard entry
    task automatic wait_done(input string tag, input bit chk_lat);
        int   n;
        exp_t e;
        n = 0;
        while (done !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        check({tag, " done"}, W'(done), W'(1));
        if (done !== 1'b1) begin
            if (scb.size() > 0) void'(scb.pop_front());
            return;
        end
        check({tag, " scb_nonempty"}, W'(scb.size() > 0), W'(1));
        if (scb.size() == 0) return;
        e = scb.pop_front();
        check({tag, " lo"}, lo, e.lo);
        check({tag, " hi"}, hi, e.hi);
        check({tag, " dbz"}, W'(div_by_zero), W'(e.dbz));
        if (chk_lat) check({tag, " latency"}, W'(cyc_cnt - start_cyc), W'(LAT));
    endtask

    function automatic exp_t mk(input logic [W-1:0] l, input logic [W-1:0] h, input logic z);
        exp_t e;
        e.lo  = l;
        e.hi  = h;
        e.dbz = z;
        return e;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   dcount;
        bit   sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst busy", W'(busy), W'(0));
        check("rst done", W'(done), W'(0));
        check("rst lo", lo, '0);
        check("rst hi", hi, '0);
        check("rst dbz", W'(div_by_zero), W'(0));
        clr = 1'b1;

        // ---- unsigned 100 / 7 with latency and busy/done shape ----
        issue(1'b0, 32'd100, 32'd7, 1'b1, mk(32'd14, 32'd2, 1'b0));
        check("u100/7 busy after start", W'(busy), W'(1));
        wait_done("u100/7", 1'b1);
        check("u100/7 busy at done", W'(busy), W'(0));
        @(negedge clk);
        check("u100/7 single done pulse", W'(done), W'(0));

        // ---- signed / unsigned directed cases ----
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0));
        wait_done("s-7/2", 1'b1);
        issue(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1, mk(32'h7FFF_FFFC, 32'd1, 1'b0));
        wait_done("uFFFFFFF9/2", 1'b0);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mk(32'h8000_0000, 32'd0, 1'b0));
        wait_done("s_min/-1", 1'b0);
        issue(1'b0, 32'h1234_5678, 32'd0, 1'b1, mk(32'hFFFF_FFFF, 32'h1234_5678, 1'b1));
        wait_done("u/0", 1'b1);
        issue(1'b1, 32'hFFFF_FF9C, 32'd0, 1'b1, mk(32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1));
        wait_done("s/0", 1'b0);
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, mk(32'hFFFF_FFFD, 32'd1, 1'b0));
        wait_done("s7/-2", 1'b0);

        // ---- start while busy is ignored; results held until next done ----
        issue(1'b0, 32'd1000, 32'd9, 1'b1, mk(32'd111, 32'd1, 1'b0));
        repeat (10) @(negedge clk);
        check("hold lo mid-op", lo, 32'hFFFF_FFFD);
        check("hold hi mid-op", hi, 32'd1);
        drive_start(1'b0, 32'd5, 32'd5, 1'b0, mk('0, '0, 1'b0));
        wait_done("ignored start", 1'b1);

        // ---- back-to-back start in the done cycle ----
        drive_start(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1, mk(32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0));
        check("b2b no double done", W'(done), W'(0));
        wait_done("b2b -100/7", 1'b1);

        // ---- asynchronous reset mid-operation ----
        issue(1'b0, 32'd50, 32'd5, 1'b0, mk('0, '0, 1'b0));
        repeat (10) @(negedge clk);
        clr = 1'b0;
        #1;
        check("clr busy", W'(busy), W'(0));
        check("clr done", W'(done), W'(0));
        check("clr lo", lo, '0);
        check("clr hi", hi, '0);
        check("clr dbz", W'(div_by_zero), W'(0));
        @(negedge clk);
        clr = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        check("no done after abort", W'(dcount), W'(0));
        issue(1'b0, 32'd9, 32'd3, 1'b1, mk(32'd3, 32'd0, 1'b0));
        wait_done("u9/3 after clr", 1'b1);

        // ---- random regression against the truncating-division model ----
        for (int i = 0; i < 200; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = '1;
                3:       begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            issue(sgn, a, b, 1'b1, ref_div(sgn, a, b));
            wait_done("rand", 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_div_seq
`default_nettype wire
